piso_stream: RTL

Parametrised parallel-in/serial-out serialiser with valid/ready load handshake, one-word holding buffer and a bit-rate enable. Successor to the fixed 4-bit PISO: width and bit order are configurable, and back-to-back words stream with no idle bit between them. Sits between a word-producing datapath and a serial line driver.

---
 rtl/piso_pkg.sv | 16 +
 rtl/piso_stream.sv | 131 +++++++++++++
 2 files changed

// File: rtl/piso_pkg.sv
// Shared types and helpers for the piso_stream serialiser.
package piso_pkg;

    // Serialiser occupancy state: IDLE means the shift register holds no word.
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } piso_state_t;

    // Bit-counter width for a given word width. The counter only needs to
    // hold WIDTH-1. The guard keeps a degenerate width from producing zero bits.
    function automatic int cnt_width(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/piso_stream.sv
// Parallel-in/serial-out serialiser with a valid/ready load port, a one-word
// holding buffer and a bit-rate strobe. While a word is being shifted out, the
// block can accept the next word into the holding buffer. When that word is
// ready at the final bit, it follows with no idle bit in between.
module piso_stream
    import piso_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] parallel_in,
    input  logic             shift_en,
    output logic             serial_out,
    output logic             serial_valid,
    output logic             last,
    output logic             busy
);

    localparam int               CNT_W   = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    piso_state_t      state_r, state_s;
    logic [WIDTH-1:0] sr_r, sr_s;
    logic [WIDTH-1:0] hold_r, hold_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic             hold_full_r, hold_full_s;
    logic             accept_s;
    logic             final_bit_s;

    // Move the word one place toward the output end. The output end depends
    // on the bit order.
    function automatic logic [WIDTH-1:0] shift_word(input logic [WIDTH-1:0] w);
        if (LSB_FIRST) begin
            return {1'b0, w[WIDTH-1:1]};
        end else begin
            return {w[WIDTH-2:0], 1'b0};
        end
    endfunction

    // Next-state logic for the FSM, shifter, counter and holding buffer.
    always_comb begin
        state_s     = state_r;
        sr_s        = sr_r;
        cnt_s       = cnt_r;
        hold_s      = hold_r;
        hold_full_s = hold_full_r;
        accept_s    = in_valid && !hold_full_r;
        final_bit_s = shift_en && (cnt_r == '0);
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    sr_s    = parallel_in;
                    cnt_s   = CNT_TOP;
                    state_s = SHIFT;
                end else begin
                    state_s = IDLE;
                end
            end
            SHIFT: begin
                if (final_bit_s) begin
                    if (hold_full_r) begin
                        // A held word takes over the shifter. The buffer
                        // cannot accept a word this cycle because it is
                        // still full.
                        sr_s        = hold_r;
                        cnt_s       = CNT_TOP;
                        hold_full_s = 1'b0;
                    end else if (accept_s) begin
                        // The incoming word bypasses the empty buffer.
                        sr_s  = parallel_in;
                        cnt_s = CNT_TOP;
                    end else begin
                        sr_s    = '0;
                        state_s = IDLE;
                    end
                end else begin
                    if (shift_en) begin
                        sr_s  = shift_word(sr_r);
                        cnt_s = cnt_r - CNT_ONE;
                    end else begin
                        cnt_s = cnt_r;
                    end
                    if (accept_s) begin
                        hold_s      = parallel_in;
                        hold_full_s = 1'b1;
                    end else begin
                        hold_full_s = hold_full_r;
                    end
                end
            end
            default: begin
                sr_s        = '0;
                cnt_s       = '0;
                hold_s      = '0;
                hold_full_s = 1'b0;
                state_s     = IDLE;
            end
        endcase
    end

    // State registers. A synchronous reset discards any word in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            sr_r        <= '0;
            cnt_r       <= '0;
            hold_r      <= '0;
            hold_full_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            sr_r        <= sr_s;
            cnt_r       <= cnt_s;
            hold_r      <= hold_s;
            hold_full_r <= hold_full_s;
        end
    end

    // Outputs decode directly from registers, so they change only on clock edges.
    assign in_ready     = !hold_full_r;
    assign serial_valid = (state_r == SHIFT);
    assign serial_out   = (state_r == SHIFT) &&
                          (LSB_FIRST ? sr_r[0] : sr_r[WIDTH-1]);
    assign last         = (state_r == SHIFT) && (cnt_r == '0);
    assign busy         = (state_r == SHIFT) || hold_full_r;

endmodule
